// File: rtl/hazard_unit_mt_if.sv
// hazard_unit_mt_if: pipeline-side hazard/miss signals between the core and the hazard unit
interface hazard_unit_mt_if #(
  parameter int NUM_THREADS = 4,
  parameter int REG_W = 5
);
  localparam int TID_W = $clog2(NUM_THREADS);
  logic MemRead_Mem;
  logic [REG_W-1:0] RegisterRD_Mem, RegisterRS1_EX, RegisterRS2_EX;
  logic [TID_W-1:0] Tid_Mem, Tid_EX, Tid_Miss, Tid_Ready;
  logic CacheMiss, Ready;
  logic stall, stall_all;
  logic [NUM_THREADS-1:0] EnablePC, parked, resume, timeout_err;
  modport master (
    output MemRead_Mem, RegisterRD_Mem, Tid_Mem, RegisterRS1_EX, RegisterRS2_EX, Tid_EX,
           CacheMiss, Tid_Miss, Ready, Tid_Ready,
    input  stall, EnablePC, parked, stall_all, resume, timeout_err
  );
  modport slave (
    input  MemRead_Mem, RegisterRD_Mem, Tid_Mem, RegisterRS1_EX, RegisterRS2_EX, Tid_EX,
           CacheMiss, Tid_Miss, Ready, Tid_Ready,
    output stall, EnablePC, parked, stall_all, resume, timeout_err
  );
endinterface

// File: rtl/hazard_unit_mt.sv
// hazard_unit_mt: per-thread load-use detection and cache-miss park/resume control
module hazard_unit_mt #(
  parameter int NUM_THREADS = 4,
  parameter int REG_W = 5,
  parameter int SWITCH_ON_MISS = 1,
  parameter int LOAD_USE_EN = 1,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic Reset,
  hazard_unit_mt_if.slave bus
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic {RUN, MISS_WAIT} state_t;
  state_t state_q [NUM_THREADS];
  state_t state_d [NUM_THREADS];
  logic [CNT_W-1:0] cnt_q [NUM_THREADS];
  logic [CNT_W-1:0] cnt_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] resume_q, resume_d, err_q, err_d, miss_v, rdy_v, parked;
  always_comb begin
    miss_v = '0;
    rdy_v = '0;
    resume_d = '0;
    err_d = err_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      miss_v[t] = bus.CacheMiss && bus.Tid_Miss == TID_W'(t);
      rdy_v[t] = bus.Ready && bus.Tid_Ready == TID_W'(t);
      state_d[t] = state_q[t] == RUN ? (miss_v[t] ? MISS_WAIT : RUN) : (rdy_v[t] ? RUN : MISS_WAIT);
      // counter restarts on entry and holds at TIMEOUT while the wait continues
      cnt_d[t] = state_q[t] == RUN ? (miss_v[t] ? '0 : cnt_q[t])
               : (cnt_q[t] == CNT_W'(TIMEOUT) ? cnt_q[t] : cnt_q[t] + CNT_W'(1));
      resume_d[t] = state_q[t] == MISS_WAIT && state_d[t] == RUN;
      err_d[t] = err_q[t] | (state_q[t] == MISS_WAIT && cnt_d[t] == CNT_W'(TIMEOUT));
    end
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= RUN;
        cnt_q[t] <= '0;
      end
      resume_q <= '0;
      err_q <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t] <= cnt_d[t];
      end
      resume_q <= resume_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    parked = '0;
    for (int t = 0; t < NUM_THREADS; t++) parked[t] = state_q[t] == MISS_WAIT;
  end
  always_comb begin
    bus.parked = parked;
    bus.resume = resume_q;
    bus.timeout_err = err_q;
    bus.stall_all = SWITCH_ON_MISS != 0 ? &parked : |parked;
    bus.stall = LOAD_USE_EN != 0 && bus.MemRead_Mem && bus.Tid_Mem == bus.Tid_EX
             && bus.RegisterRD_Mem != REG_W'(0)
             && (bus.RegisterRD_Mem == bus.RegisterRS1_EX || bus.RegisterRD_Mem == bus.RegisterRS2_EX)
             && !parked[bus.Tid_EX];
    bus.EnablePC = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      bus.EnablePC[t] = !parked[t] && !bus.stall_all && !(bus.stall && bus.Tid_EX == TID_W'(t));
  end
endmodule

// File: tb/tb_hazard_unit_mt.sv
// tb_hazard_unit_mt: scoreboard bench over three configurations of hazard_unit_mt
module tb_hazard_unit_mt;
  logic clk = 0, Reset = 1;
  always #5 clk = ~clk;
  hazard_unit_mt_if i0(), i1(), i2();
  hazard_unit_mt u0 (.clk(clk), .Reset(Reset), .bus(i0.slave));
  hazard_unit_mt #(.SWITCH_ON_MISS(0)) u1 (.clk(clk), .Reset(Reset), .bus(i1.slave));
  hazard_unit_mt #(.TIMEOUT(7)) u2 (.clk(clk), .Reset(Reset), .bus(i2.slave));
  int checks = 0, errors = 0;
  logic [17:0] sb [$];
  logic [17:0] e, o;

  function automatic logic [17:0] mk(logic st, logic sa, logic [3:0] en, logic [3:0] pk,
                                     logic [3:0] rs, logic [3:0] te);
    return {st, sa, en, pk, rs, te};
  endfunction

  function automatic logic [17:0] obs(int k);
    if (k == 0) return {i0.stall, i0.stall_all, i0.EnablePC, i0.parked, i0.resume, i0.timeout_err};
    if (k == 1) return {i1.stall, i1.stall_all, i1.EnablePC, i1.parked, i1.resume, i1.timeout_err};
    return {i2.stall, i2.stall_all, i2.EnablePC, i2.parked, i2.resume, i2.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    i0.CacheMiss = 0; i0.Ready = 0;
    i1.CacheMiss = 0; i1.Ready = 0;
    i2.CacheMiss = 0; i2.Ready = 0;
    #1;
  endtask

  task automatic init();
    i0.MemRead_Mem = 0; i0.RegisterRD_Mem = 0; i0.RegisterRS1_EX = 0; i0.RegisterRS2_EX = 0;
    i0.Tid_Mem = 0; i0.Tid_EX = 0; i0.CacheMiss = 0; i0.Tid_Miss = 0; i0.Ready = 0; i0.Tid_Ready = 0;
    i1.MemRead_Mem = 0; i1.RegisterRD_Mem = 0; i1.RegisterRS1_EX = 0; i1.RegisterRS2_EX = 0;
    i1.Tid_Mem = 0; i1.Tid_EX = 0; i1.CacheMiss = 0; i1.Tid_Miss = 0; i1.Ready = 0; i1.Tid_Ready = 0;
    i2.MemRead_Mem = 0; i2.RegisterRD_Mem = 0; i2.RegisterRS1_EX = 0; i2.RegisterRS2_EX = 0;
    i2.Tid_Mem = 0; i2.Tid_EX = 0; i2.CacheMiss = 0; i2.Tid_Miss = 0; i2.Ready = 0; i2.Tid_Ready = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    tick();
    for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 4'hF, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front(); o = obs(k); checks++;
      if (o !== e) begin errors++; $display("FAIL reset[%0d]: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_load_use();
    logic [4:0] rd [4] = '{5, 5, 0, 7};
    logic [4:0] r1 [4] = '{5, 5, 0, 3};
    logic [4:0] r2 [4] = '{0, 0, 0, 7};
    logic [1:0] tm [4] = '{2, 2, 2, 3};
    logic [1:0] tx [4] = '{2, 1, 2, 3};
    logic       st [4] = '{1, 0, 0, 1};
    for (int s = 0; s < 4; s++) begin
      i0.MemRead_Mem = 1; i0.RegisterRD_Mem = rd[s]; i0.RegisterRS1_EX = r1[s];
      i0.RegisterRS2_EX = r2[s]; i0.Tid_Mem = tm[s]; i0.Tid_EX = tx[s];
      sb.push_back(mk(st[s], 0, st[s] ? ~(4'b0001 << tx[s]) : 4'hF, 0, 0, 0));
      #1;
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL load_use[%0d]: got %h expected %h", s, o, e); end
    end
    i0.MemRead_Mem = 0;
  endtask

  task automatic test_single_miss();
    int mt [6] = '{1, -1, 1, -1, -1, -1};
    int rt [6] = '{-1, -1, -1, 1, -1, 3};
    logic [17:0] ex [6];
    ex[0] = mk(0, 0, 4'b1101, 4'b0010, 0, 0);
    ex[1] = ex[0];
    ex[2] = ex[0];
    ex[3] = mk(0, 0, 4'hF, 0, 4'b0010, 0);
    ex[4] = mk(0, 0, 4'hF, 0, 0, 0);
    ex[5] = ex[4];
    for (int s = 0; s < 6; s++) begin
      i0.CacheMiss = mt[s] >= 0; i0.Tid_Miss = 2'(mt[s]);
      i0.Ready = rt[s] >= 0; i0.Tid_Ready = 2'(rt[s]);
      sb.push_back(ex[s]);
      tick();
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL single_miss[%0d]: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_all_miss();
    int mt [8] = '{0, 1, 2, 3, -1, -1, -1, -1};
    int rt [8] = '{-1, -1, -1, -1, 2, 0, 1, 3};
    logic [17:0] ex [8];
    ex[0] = mk(0, 0, 4'b1110, 4'b0001, 0, 0);
    ex[1] = mk(0, 0, 4'b1100, 4'b0011, 0, 0);
    ex[2] = mk(0, 0, 4'b1000, 4'b0111, 0, 0);
    ex[3] = mk(0, 1, 4'b0000, 4'b1111, 0, 0);
    ex[4] = mk(0, 0, 4'b0100, 4'b1011, 4'b0100, 0);
    ex[5] = mk(0, 0, 4'b0101, 4'b1010, 4'b0001, 0);
    ex[6] = mk(0, 0, 4'b0111, 4'b1000, 4'b0010, 0);
    ex[7] = mk(0, 0, 4'b1111, 4'b0000, 4'b1000, 0);
    for (int s = 0; s < 8; s++) begin
      i0.CacheMiss = mt[s] >= 0; i0.Tid_Miss = 2'(mt[s]);
      i0.Ready = rt[s] >= 0; i0.Tid_Ready = 2'(rt[s]);
      sb.push_back(ex[s]);
      tick();
      e = sb.pop_front(); o = obs(0); checks++;
      if (o !== e) begin errors++; $display("FAIL all_miss[%0d]: got %h expected %h", s, o, e); end
      if (s == 4) begin
        // a hazard on a parked thread is suppressed; the same hazard on a running thread stalls
        for (int j = 0; j < 2; j++) begin
          i0.MemRead_Mem = 1; i0.RegisterRD_Mem = 9; i0.RegisterRS1_EX = 9; i0.RegisterRS2_EX = 0;
          i0.Tid_Mem = j == 0 ? 2'd0 : 2'd2; i0.Tid_EX = i0.Tid_Mem;
          sb.push_back(j == 0 ? ex[4] : mk(1, 0, 4'b0000, 4'b1011, 4'b0100, 0));
          #1;
          e = sb.pop_front(); o = obs(0); checks++;
          if (o !== e) begin errors++; $display("FAIL parked_load_use[%0d]: got %h expected %h", j, o, e); end
        end
        i0.MemRead_Mem = 0;
      end
    end
  endtask

  task automatic test_stall_all_legacy();
    int mt [6] = '{3, -1, 0, 0, 2, -1};
    int rt [6] = '{-1, -1, 3, 0, 2, 2};
    logic [17:0] ex [6];
    ex[0] = mk(0, 1, 0, 4'b1000, 0, 0);
    ex[1] = ex[0];
    ex[2] = mk(0, 1, 0, 4'b0001, 4'b1000, 0);
    ex[3] = mk(0, 0, 4'hF, 0, 4'b0001, 0);
    ex[4] = mk(0, 1, 0, 4'b0100, 0, 0);
    ex[5] = mk(0, 0, 4'hF, 0, 4'b0100, 0);
    for (int s = 0; s < 6; s++) begin
      i1.CacheMiss = mt[s] >= 0; i1.Tid_Miss = 2'(mt[s]);
      i1.Ready = rt[s] >= 0; i1.Tid_Ready = 2'(rt[s]);
      sb.push_back(ex[s]);
      tick();
      e = sb.pop_front(); o = obs(1); checks++;
      if (o !== e) begin errors++; $display("FAIL legacy[%0d]: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_timeout();
    i2.CacheMiss = 1; i2.Tid_Miss = 0;
    for (int s = 0; s < 9; s++) begin
      sb.push_back(mk(0, 0, 4'b1110, 4'b0001, 0, {3'b000, s >= 7}));
      tick();
      e = sb.pop_front(); o = obs(2); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout[%0d]: got %h expected %h", s, o, e); end
    end
    Reset = 1;
    sb.push_back(mk(0, 0, 4'hF, 0, 0, 0));
    tick();
    Reset = 0;
    e = sb.pop_front(); o = obs(2); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid_wait: got %h expected %h", o, e); end
    i2.Ready = 1; i2.Tid_Ready = 0;
    sb.push_back(mk(0, 0, 4'hF, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = obs(2); checks++;
    if (o !== e) begin errors++; $display("FAIL stale_ready: got %h expected %h", o, e); end
  endtask

  initial begin
    init();
    test_reset();
    test_load_use();
    test_single_miss();
    test_all_miss();
    test_stall_all_legacy();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
